// File: rtl/agp32_mem_unit_if.sv
// MEM-stage request/response channel and shared memory command bus of agp32_mem_unit.
// slave = the unit itself, master = pipeline/memory/host side.
interface agp32_mem_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int LANES = DATA_W / 8;

  logic              req_valid;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic              bus_error;
  logic [2:0]        command;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [LANES-1:0]  mem_wstrb;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        mem_error;
  logic              mem_start_ready;
  logic              interrupt_req;
  logic              interrupt_ack;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    input  mem_ready, mem_rdata, mem_error, mem_start_ready, interrupt_ack,
    output req_ready, resp_valid, resp_data, resp_err, bus_error,
    output command, mem_addr, mem_wdata, mem_wstrb, interrupt_req
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    output mem_ready, mem_rdata, mem_error, mem_start_ready, interrupt_ack,
    input  req_ready, resp_valid, resp_data, resp_err, bus_error,
    input  command, mem_addr, mem_wdata, mem_wstrb, interrupt_req
  );
endinterface

// File: rtl/agp32_mem_unit.sv
// agp32 MEM-stage sequencer: memory read/write, host interrupt and a small
// half-word-add accelerator, with response timeout and sticky bus error.
//
//   state | meaning
//   INIT  | waiting for memory power-up (mem_start_ready)
//   IDLE  | ready for a request
//   WAIT  | command issued, waiting for mem_ready
//   IRQ   | interrupt raised, waiting for interrupt_ack
//   ACC   | accelerator running, ACC_LAT cycles
//   DONE  | one-cycle response pulse
//   ERROR | bus error seen, left only by reset
module agp32_mem_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int ACC_LAT = 2
) (
  input logic             clk,
  input logic             rst_n,
  agp32_mem_unit_if.slave bus
);
  localparam int LANES = DATA_W / 8;
  localparam int LB    = $clog2(LANES);
  localparam int HW    = DATA_W / 2;
  localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int AW    = $clog2(ACC_LAT + 1);
  localparam logic [TW-1:0] T_LOAD = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [AW-1:0] A_LOAD = AW'(ACC_LAT - 1);

  localparam logic [2:0] OP_RD_W = 3'd1;
  localparam logic [2:0] OP_RD_B = 3'd2;
  localparam logic [2:0] OP_WR_W = 3'd3;
  localparam logic [2:0] OP_WR_B = 3'd4;
  localparam logic [2:0] OP_IRQ  = 3'd5;
  localparam logic [2:0] OP_ACC  = 3'd6;

  localparam logic [2:0] CMD_NONE = 3'd0;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_IRQ  = 3'd4;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_WAIT, S_IRQ, S_ACC, S_DONE, S_ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LANES-1:0]  wstrb_q, wstrb_d;
  logic              irq_q, irq_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              berr_q, berr_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [2:0]        op_q, op_d;
  logic              first_q, first_d;

  logic [HW-1:0]     acc_sum;
  logic [7:0]        rd_byte;
  logic              tmo_hit;

  assign acc_sum = opnd_q[DATA_W-1:HW] + opnd_q[HW-1:0];
  assign rd_byte = 8'(bus.mem_rdata >> {addr_q[LB-1:0], 3'b000});
  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cmd_q   <= CMD_NONE;
      addr_q  <= '1;
      wdata_q <= '0;
      wstrb_q <= '0;
      irq_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      berr_q  <= 1'b0;
      tmo_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      irq_q   <= irq_d;
      data_q  <= data_d;
      err_q   <= err_d;
      berr_q  <= berr_d;
      tmo_q   <= tmo_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = CMD_NONE;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    irq_d   = irq_q;
    data_d  = data_q;
    err_d   = err_q;
    berr_d  = berr_q;
    tmo_d   = tmo_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    first_d = 1'b0;

    case (state_q)
      S_INIT: if (bus.mem_start_ready) state_d = S_IDLE;

      S_IDLE: if (bus.req_valid) begin
        op_d  = bus.req_op;
        err_d = 1'b0;
        case (bus.req_op)
          OP_RD_W, OP_RD_B: begin
            cmd_d  = CMD_RD;
            addr_d = bus.req_addr;
          end
          OP_WR_W: begin
            cmd_d   = CMD_WR;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            wstrb_d = '1;
          end
          OP_WR_B: begin
            cmd_d   = CMD_WR;
            addr_d  = bus.req_addr;
            wdata_d = {LANES{bus.req_wdata[7:0]}};
            wstrb_d = LANES'(1) << bus.req_addr[LB-1:0];
          end
          OP_IRQ: begin
            cmd_d  = CMD_IRQ;
            addr_d = '0;
          end
          OP_ACC: begin
            opnd_d  = bus.req_wdata;
            acc_d   = A_LOAD;
            state_d = S_ACC;
          end
          default: begin
            data_d  = '0;
            state_d = S_DONE;
          end
        endcase
        if (cmd_d != CMD_NONE) begin
          state_d = S_WAIT;
          tmo_d   = T_LOAD;
          first_d = 1'b1;
        end
      end

      // mem_ready in the issue cycle belongs to the previous transaction
      S_WAIT: begin
        if (!first_q && bus.mem_ready) begin
          if (op_q == OP_RD_W) data_d = bus.mem_rdata;
          else if (op_q == OP_RD_B) data_d = DATA_W'(rd_byte);
          if (op_q == OP_IRQ) begin
            irq_d   = 1'b1;
            tmo_d   = T_LOAD;
            state_d = S_IRQ;
          end else begin
            state_d = S_DONE;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (tmo_q != '0) begin
          tmo_d = tmo_q - 1'b1;
        end
      end

      S_IRQ: begin
        if (bus.interrupt_ack) begin
          irq_d   = 1'b0;
          state_d = S_DONE;
        end else if (tmo_hit) begin
          irq_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (tmo_q != '0) begin
          tmo_d = tmo_q - 1'b1;
        end
      end

      S_ACC: begin
        if (acc_q == '0) begin
          data_d  = DATA_W'(acc_sum);
          state_d = S_DONE;
        end else begin
          acc_d = acc_q - 1'b1;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase

    // a bus error overrides any completion in the same cycle
    if (state_q != S_INIT && bus.mem_error != 2'b00) begin
      state_d = S_ERROR;
      berr_d  = 1'b1;
      cmd_d   = CMD_NONE;
      irq_d   = 1'b0;
    end
  end

  assign bus.req_ready     = (state_q == S_IDLE);
  assign bus.resp_valid    = (state_q == S_DONE);
  assign bus.resp_err      = (state_q == S_DONE) && err_q;
  assign bus.resp_data     = data_q;
  assign bus.bus_error     = berr_q;
  assign bus.command       = cmd_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wstrb     = wstrb_q;
  assign bus.interrupt_req = irq_q;
endmodule

// File: tb/tb_agp32_mem_unit.sv
// Scoreboard bench for agp32_mem_unit (64-bit data, short timeout).
module tb_agp32_mem_unit;
  localparam int DW  = 64;
  localparam int AWD = 32;
  localparam int TMO = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  agp32_mem_unit_if #(.DATA_W(DW), .ADDR_W(AWD)) bus ();

  agp32_mem_unit #(.DATA_W(DW), .ADDR_W(AWD), .TIMEOUT(TMO), .ACC_LAT(LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [63:0] m_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp_valid", 64'(bus.resp_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_data", bus.resp_data, mon_e.data);
        chk("resp_err", 64'(bus.resp_err), 64'(mon_e.err));
        chk("resp_latency", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  // Drive one request, model its response, play memory/host for it.
  task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [63:0] wdata,
                        input int dly, input logic [63:0] rdata, input int ack_dly);
    exp_t       e;
    int         lat;
    int         n;
    logic [2:0] ecmd;
    logic [7:0] estrb;

    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_before", 64'(bus.req_ready), 64'd1);

    e.err  = 1'b0;
    e.data = m_data;
    ecmd   = 3'd0;
    lat    = 1;
    case (op)
      3'd1, 3'd2, 3'd3, 3'd4: begin
        ecmd = (op <= 3'd2) ? 3'd2 : 3'd3;
        if (dly < TMO) begin
          lat = 2 + dly;
          if (op == 3'd1) e.data = rdata;
          if (op == 3'd2) e.data = (rdata >> (8 * int'(addr[2:0]))) & 64'hFF;
        end else begin
          lat   = TMO + 1;
          e.err = 1'b1;
        end
      end
      3'd5: begin
        ecmd = 3'd4;
        if (dly >= TMO) begin
          lat   = TMO + 1;
          e.err = 1'b1;
        end else if (ack_dly >= 1 && ack_dly <= TMO) begin
          lat = 2 + dly + ack_dly;
        end else begin
          lat   = 2 + dly + TMO;
          e.err = 1'b1;
        end
      end
      3'd6: begin
        e.data = {32'h0, 32'(wdata[63:32] + wdata[31:0])};
        lat    = LAT + 1;
      end
      default: e.data = '0;
    endcase
    m_data = e.data;
    e.cyc  = cyc + lat;
    sb.push_back(e);

    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("command_issue", 64'(bus.command), 64'(ecmd));

    if (ecmd != 3'd0) begin
      chk("mem_addr", 64'(bus.mem_addr), (op == 3'd5) ? 64'd0 : 64'(addr));
      if (op == 3'd3) begin
        chk("mem_wstrb_word", 64'(bus.mem_wstrb), 64'hFF);
        chk("mem_wdata_word", bus.mem_wdata, wdata);
      end
      if (op == 3'd4) begin
        estrb = 8'(1) << addr[2:0];
        chk("mem_wstrb_byte", 64'(bus.mem_wstrb), 64'(estrb));
        chk("mem_wdata_byte", bus.mem_wdata, {8{wdata[7:0]}});
      end
      @(negedge clk);
      chk("command_one_cycle", 64'(bus.command), 64'd0);
      repeat (dly - 1) @(negedge clk);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = rdata;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (op == 3'd5 && dly < TMO) begin
        chk("interrupt_req_high", 64'(bus.interrupt_req), 64'd1);
        if (ack_dly >= 1) begin
          repeat (ack_dly - 1) @(negedge clk);
          bus.interrupt_ack = 1'b1;
          @(negedge clk);
          bus.interrupt_ack = 1'b0;
        end
      end
    end

    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("resp_arrived", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
    chk("resp_valid_pulse", 64'(bus.resp_valid), 64'd0);
    chk("req_ready_after", 64'(bus.req_ready), 64'd1);
    if (op == 3'd5) chk("interrupt_req_low", 64'(bus.interrupt_req), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid       = 1'b0;
    bus.req_op          = 3'd0;
    bus.req_addr        = '0;
    bus.req_wdata       = '0;
    bus.mem_ready       = 1'b0;
    bus.mem_rdata       = '0;
    bus.mem_error       = 2'd0;
    bus.mem_start_ready = 1'b0;
    bus.interrupt_ack   = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'hFFFF_FFFF);
    chk("rst_command", 64'(bus.command), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_resp_data", bus.resp_data, 64'd0);
    chk("rst_wstrb", 64'(bus.mem_wstrb), 64'd0);
    chk("rst_bus_error", 64'(bus.bus_error), 64'd0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("init_req_ready_c1", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    chk("init_req_ready_c2", 64'(bus.req_ready), 64'd0);
    chk("init_mem_addr", 64'(bus.mem_addr), 64'hFFFF_FFFF);
    bus.mem_start_ready = 1'b1;
    @(negedge clk);
    chk("init_req_ready_c4", 64'(bus.req_ready), 64'd1);

    run_op(3'd0, 32'h0, 64'h0, 0, 64'h0, 0);
    run_op(3'd1, 32'h100, 64'h0, 1, 64'h1122_3344_5566_7788, 0);
    run_op(3'd2, 32'h102, 64'h0, 3, 64'hAABB_CCDD, 0);
    run_op(3'd3, 32'h200, 64'hDEAD_BEEF_0123_4567, 2, 64'h0, 0);
    run_op(3'd4, 32'h7, 64'h5A, 1, 64'h0, 0);
    run_op(3'd6, 32'h0, 64'hFFFF_FFFF_0000_0002, 0, 64'h0, 0);
    run_op(3'd6, 32'h0, 64'h0000_0003_0000_0004, 0, 64'h0, 0);
    run_op(3'd1, 32'h300, 64'h0, 4, 64'h9999, 0);
    run_op(3'd5, 32'h0, 64'h0, 1, 64'h0, 2);
    run_op(3'd5, 32'h0, 64'h0, 1, 64'h0, 0);
    run_op(3'd7, 32'h0, 64'h0, 0, 64'h0, 0);

    // bus error during a write wait, with mem_ready in the same cycle
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd3;
    bus.req_addr  = 32'h400;
    bus.req_wdata = 64'h1234;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("err_command_issue", 64'(bus.command), 64'd3);
    @(negedge clk);
    bus.mem_ready = 1'b1;
    bus.mem_error = 2'd1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    bus.mem_error = 2'd0;
    chk("err_bus_error", 64'(bus.bus_error), 64'd1);
    chk("err_req_ready", 64'(bus.req_ready), 64'd0);
    chk("err_command", 64'(bus.command), 64'd0);
    repeat (5) @(negedge clk);
    chk("err_sticky", 64'(bus.bus_error), 64'd1);
    chk("err_req_ready_held", 64'(bus.req_ready), 64'd0);

    rst_n = 1'b0;
    #1;
    chk("arst_bus_error", 64'(bus.bus_error), 64'd0);
    chk("arst_mem_addr", 64'(bus.mem_addr), 64'hFFFF_FFFF);
    m_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("recover_req_ready", 64'(bus.req_ready), 64'd1);
    run_op(3'd2, 32'h5, 64'h0, 2, 64'h0011_2233_4455_6677, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
